// File: rtl/count_checker.sv
// Sequence checker for a free-running up-counter: hunts for LOCK_COUNT consecutive
// increments, then flags breaks and wraps and keeps a saturating error count.
module count_checker #(
  parameter int unsigned WIDTH      = 7,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned ERR_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] q_in,
  input  logic             valid_in,
  input  logic             clear_err,
  output logic             locked,
  output logic             err_pulse,
  output logic             wrap_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] expected
);

  typedef enum logic [1:0] {StIdle, StHunt, StLocked} state_e;

  localparam logic [3:0] LockRun = 4'(LOCK_COUNT);

  state_e           state_q, state_d;
  logic [3:0]       run_q, run_d;
  logic [WIDTH-1:0] expected_q, expected_d;
  logic             locked_q, locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic             wrap_pulse_q, wrap_pulse_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic             err_hit;

  always_comb begin
    state_d      = state_q;
    run_d        = run_q;
    expected_d   = expected_q;
    locked_d     = locked_q;
    err_pulse_d  = 1'b0;
    wrap_pulse_d = 1'b0;
    err_hit      = 1'b0;

    if (valid_in) begin
      // Always resynchronise on the observed value, so one glitch costs one error.
      expected_d = q_in + WIDTH'(1);
      unique case (state_q)
        StIdle: begin
          run_d   = 4'd0;
          state_d = StHunt;
        end
        StHunt: begin
          if (q_in == expected_q) begin
            run_d = run_q + 4'd1;
            if (run_d == LockRun) begin
              state_d  = StLocked;
              locked_d = 1'b1;
            end
          end else begin
            run_d = 4'd0;
          end
        end
        StLocked: begin
          if (q_in == expected_q) begin
            wrap_pulse_d = (q_in == '0);
          end else begin
            err_pulse_d = 1'b1;
            err_hit     = 1'b1;
            run_d       = 4'd0;
            state_d     = StHunt;
            locked_d    = 1'b0;
          end
        end
        default: begin
          state_d  = StIdle;
          locked_d = 1'b0;
        end
      endcase
    end

    // Clear wins over a coincident error; the pulse itself still fires.
    err_count_d = err_count_q;
    if (clear_err) begin
      err_count_d = '0;
    end else if (err_hit && (err_count_q != '1)) begin
      err_count_d = err_count_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      run_q        <= 4'd0;
      expected_q   <= '0;
      locked_q     <= 1'b0;
      err_pulse_q  <= 1'b0;
      wrap_pulse_q <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      run_q        <= run_d;
      expected_q   <= expected_d;
      locked_q     <= locked_d;
      err_pulse_q  <= err_pulse_d;
      wrap_pulse_q <= wrap_pulse_d;
      err_count_q  <= err_count_d;
    end
  end

  assign locked     = locked_q;
  assign err_pulse  = err_pulse_q;
  assign wrap_pulse = wrap_pulse_q;
  assign err_count  = err_count_q;
  assign expected   = expected_q;

endmodule

// File: tb/tb_count_checker.sv
// Directed bench for count_checker: default instance for sequencing, a second
// instance with a 2-bit error counter and LOCK_COUNT=1 for saturation and clear.
module tb_count_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] q1, q2;
  logic       v1, v2, c1, c2;
  logic       locked1, err_pulse1, wrap_pulse1;
  logic [7:0] err_count1;
  logic [6:0] expected1;
  logic       locked2, err_pulse2, wrap_pulse2;
  logic [1:0] err_count2;
  logic [6:0] expected2;

  int n_checks = 0;
  int n_fail   = 0;
  int sat [5]  = '{1, 2, 3, 3, 3};

  always #5 clk = ~clk;

  count_checker dut1 (
    .clk        (clk),
    .reset      (reset),
    .q_in       (q1),
    .valid_in   (v1),
    .clear_err  (c1),
    .locked     (locked1),
    .err_pulse  (err_pulse1),
    .wrap_pulse (wrap_pulse1),
    .err_count  (err_count1),
    .expected   (expected1)
  );

  count_checker #(.WIDTH(7), .LOCK_COUNT(1), .ERR_W(2)) dut2 (
    .clk        (clk),
    .reset      (reset),
    .q_in       (q2),
    .valid_in   (v2),
    .clear_err  (c2),
    .locked     (locked2),
    .err_pulse  (err_pulse2),
    .wrap_pulse (wrap_pulse2),
    .err_count  (err_count2),
    .expected   (expected2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step1(input logic v, input int q, input logic c);
    v1 = v;
    q1 = 7'(q);
    c1 = c;
    @(posedge clk);
    #1;
  endtask

  task automatic step2(input logic v, input int q, input logic c);
    v2 = v;
    q2 = 7'(q);
    c2 = c;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_clear(input string tag);
    chk({tag, "_locked"}, 32'(locked1), 0);
    chk({tag, "_err_pulse"}, 32'(err_pulse1), 0);
    chk({tag, "_wrap_pulse"}, 32'(wrap_pulse1), 0);
    chk({tag, "_err_count"}, 32'(err_count1), 0);
    chk({tag, "_expected"}, 32'(expected1), 0);
  endtask

  initial begin
    reset = 1'b0;
    v1 = 1'b0; q1 = '0; c1 = 1'b0;
    v2 = 1'b0; q2 = '0; c2 = 1'b0;
    #2;
    check_all_clear("reset");
    chk("reset_err_count2", 32'(err_count2), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Acquire lock on 0..4
    for (int i = 0; i < 5; i++) begin
      step1(1'b1, i, 1'b0);
      if (i == 3) chk("lock_not_yet", 32'(locked1), 0);
    end
    chk("lock_locked", 32'(locked1), 1);
    chk("lock_expected", 32'(expected1), 5);
    chk("lock_err_count", 32'(err_count1), 0);

    // Gap in valid_in while locked
    step1(1'b1, 5, 1'b0);
    step1(1'b1, 6, 1'b0);
    step1(1'b1, 7, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step1(1'b0, 0, 1'b0);
      chk("gap_locked", 32'(locked1), 1);
      chk("gap_expected", 32'(expected1), 8);
      chk("gap_err_pulse", 32'(err_pulse1), 0);
      chk("gap_wrap_pulse", 32'(wrap_pulse1), 0);
    end
    step1(1'b1, 8, 1'b0);
    chk("gap_s8_locked", 32'(locked1), 1);
    chk("gap_s8_err_pulse", 32'(err_pulse1), 0);
    chk("gap_s8_expected", 32'(expected1), 9);
    step1(1'b1, 9, 1'b0);

    // Sequence break at expected=10, then relock on 13..16
    step1(1'b1, 12, 1'b0);
    chk("brk_err_pulse", 32'(err_pulse1), 1);
    chk("brk_locked", 32'(locked1), 0);
    chk("brk_err_count", 32'(err_count1), 1);
    chk("brk_expected", 32'(expected1), 13);
    step1(1'b1, 13, 1'b0);
    chk("brk_pulse_once", 32'(err_pulse1), 0);
    step1(1'b1, 14, 1'b0);
    step1(1'b1, 15, 1'b0);
    chk("relock_not_yet", 32'(locked1), 0);
    step1(1'b1, 16, 1'b0);
    chk("relock_locked", 32'(locked1), 1);
    chk("relock_expected", 32'(expected1), 17);

    // Break to 121, relock through 125, then wrap 126,127,0
    step1(1'b1, 121, 1'b0);
    chk("wrapset_err_pulse", 32'(err_pulse1), 1);
    chk("wrapset_err_count", 32'(err_count1), 2);
    for (int i = 122; i <= 125; i++) step1(1'b1, i, 1'b0);
    chk("wrapset_locked", 32'(locked1), 1);
    chk("wrapset_expected", 32'(expected1), 126);
    step1(1'b1, 126, 1'b0);
    chk("wrap_126_pulse", 32'(wrap_pulse1), 0);
    step1(1'b1, 127, 1'b0);
    chk("wrap_127_pulse", 32'(wrap_pulse1), 0);
    chk("wrap_127_expected", 32'(expected1), 0);
    step1(1'b1, 0, 1'b0);
    chk("wrap_0_pulse", 32'(wrap_pulse1), 1);
    chk("wrap_0_locked", 32'(locked1), 1);
    chk("wrap_0_err_pulse", 32'(err_pulse1), 0);
    chk("wrap_0_expected", 32'(expected1), 1);

    // Asynchronous reset during the wrap pulse
    reset = 1'b0;
    #1;
    check_all_clear("midreset");
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Hunt with a mismatch: 5,6,9 then 10,11,12 must not lock yet
    step1(1'b1, 5, 1'b0);
    chk("hunt_first_locked", 32'(locked1), 0);
    chk("hunt_first_expected", 32'(expected1), 6);
    step1(1'b1, 6, 1'b0);
    step1(1'b1, 9, 1'b0);
    chk("hunt_miss_err_pulse", 32'(err_pulse1), 0);
    chk("hunt_miss_err_count", 32'(err_count1), 0);
    chk("hunt_miss_expected", 32'(expected1), 10);
    step1(1'b1, 10, 1'b0);
    step1(1'b1, 11, 1'b0);
    step1(1'b1, 12, 1'b0);
    chk("hunt_three_locked", 32'(locked1), 0);
    step1(1'b1, 13, 1'b0);
    chk("hunt_four_locked", 32'(locked1), 1);

    // Wrap during hunt counts as an increment without a wrap pulse
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    step1(1'b1, 126, 1'b0);
    step1(1'b1, 127, 1'b0);
    chk("huntwrap_expected", 32'(expected1), 0);
    step1(1'b1, 0, 1'b0);
    chk("huntwrap_pulse", 32'(wrap_pulse1), 0);
    chk("huntwrap_expected1", 32'(expected1), 1);
    step1(1'b1, 1, 1'b0);
    step1(1'b1, 2, 1'b0);
    chk("huntwrap_locked", 32'(locked1), 1);
    step1(1'b0, 0, 1'b0);

    // Saturating 2-bit error counter (LOCK_COUNT=1 relocks in one sample)
    step2(1'b1, 0, 1'b0);
    step2(1'b1, 1, 1'b0);
    chk("sat_locked", 32'(locked2), 1);
    for (int i = 0; i < 5; i++) begin
      step2(1'b1, 20 * (i + 1), 1'b0);
      chk("sat_err_pulse", 32'(err_pulse2), 1);
      chk("sat_err_count", 32'(err_count2), 32'(sat[i]));
      step2(1'b1, 20 * (i + 1) + 1, 1'b0);
      chk("sat_relock", 32'(locked2), 1);
      chk("sat_hold", 32'(err_count2), 32'(sat[i]));
    end
    step2(1'b1, 50, 1'b1);
    chk("clr_err_count", 32'(err_count2), 0);
    chk("clr_err_pulse", 32'(err_pulse2), 1);
    step2(1'b1, 51, 1'b0);
    step2(1'b1, 70, 1'b0);
    chk("clr2_err_count", 32'(err_count2), 1);
    step2(1'b0, 0, 1'b1);
    chk("clr_novalid_count", 32'(err_count2), 0);
    chk("clr_novalid_pulse", 32'(err_pulse2), 0);
    chk("clr_novalid_expected", 32'(expected2), 71);
    step2(1'b0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
